sobel_stream_ctrl: RTL

Sequencer that feeds the free-running 3x3 Sobel datapath from a raster pixel stream.
- Holds two line buffers and forms the 3x3 window z0..z8, with z0 top-left, z2 top-right, z6 bottom-left and z8 bottom-right.
- Tracks the Sobel pipeline latency and re-tags the thresholded edge_out with valid and centre coordinates.
- Emits one result per interior pixel per frame, plus an end-of-frame pulse.
- Sits between the video capture path and the edge-overlay/selectbit logic.

---
 rtl/sobel_pkg.sv | 18 +
 rtl/sobel_line_buf.sv | 24 ++
 rtl/sobel_stream_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel edge path: pixel/coordinate widths,
// controller states and the edge/no-edge codes used by datapath and selectbit.
package sobel_pkg;

  localparam int PIX_W   = 8;
  localparam int COORD_W = 10;

  localparam logic [PIX_W-1:0] EDGE_ON  = 8'h00;
  localparam logic [PIX_W-1:0] EDGE_OFF = 8'hff;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DRAIN,
    ST_DONE
  } ctrl_state_t;

endpackage

// File: rtl/sobel_line_buf.sv
// One video line of pixel storage; combinational read of the old word and write
// of the new word at the same address on the clock edge (read-before-write), no backpressure.
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wr_dat,
  output logic [PIX_W-1:0] rd_dat
);

  logic [PIX_W-1:0] mem [DEPTH];

  assign rd_dat = mem[addr];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wr_dat;
  end

endmodule

// File: rtl/sobel_stream_ctrl.sv
// Raster stream -> 3x3 window sequencer for the free-running Sobel datapath; results are
// re-tagged 1+SOBEL_LAT clocks after the completing pixel. No backpressure: pix_valid gaps just stall the window.
module sobel_stream_ctrl
  import sobel_pkg::*;
#(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int SOBEL_LAT = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [PIX_W-1:0]   pix_in,
  input  logic               pix_valid,
  input  logic               sof,
  output logic [PIX_W-1:0]   z0,
  output logic [PIX_W-1:0]   z1,
  output logic [PIX_W-1:0]   z2,
  output logic [PIX_W-1:0]   z3,
  output logic [PIX_W-1:0]   z4,
  output logic [PIX_W-1:0]   z5,
  output logic [PIX_W-1:0]   z6,
  output logic [PIX_W-1:0]   z7,
  output logic [PIX_W-1:0]   z8,
  input  logic [PIX_W-1:0]   sobel_edge,
  output logic [PIX_W-1:0]   edge_out,
  output logic               edge_valid,
  output logic [COORD_W-1:0] edge_x,
  output logic [COORD_W-1:0] edge_y,
  output logic               frame_done,
  output logic               busy
);

  localparam int AW = $clog2(WIDTH);
  localparam int DW = $clog2(SOBEL_LAT + 1);

  if (WIDTH > 1024 || HEIGHT > 1024 || WIDTH < 3 || HEIGHT < 3 || SOBEL_LAT < 1) begin : g_bad_params
    $error("sobel_stream_ctrl: WIDTH/HEIGHT must be 3..1024 and SOBEL_LAT >= 1");
  end

  ctrl_state_t state_q, state_d;

  logic [COORD_W-1:0] x_q, y_q;
  logic [COORD_W-1:0] cur_x, cur_y;
  logic [DW-1:0]      drain_cnt;
  logic               accept, restart, last_pix;
  logic [PIX_W-1:0]   l0_rd, l1_rd;

  logic               win_valid;
  logic [COORD_W-1:0] win_cx, win_cy;

  logic [SOBEL_LAT-1:0]              dly_vld;
  logic [SOBEL_LAT-1:0][COORD_W-1:0] dly_x;
  logic [SOBEL_LAT-1:0][COORD_W-1:0] dly_y;

  // An sof-qualified pixel is always (0,0), whatever the counters hold.
  assign cur_x    = sof ? '0 : x_q;
  assign cur_y    = sof ? '0 : y_q;
  assign restart  = pix_valid && sof;
  assign accept   = pix_valid && (sof || (state_q == ST_ACTIVE));
  assign last_pix = (cur_x == COORD_W'(WIDTH - 1)) && (cur_y == COORD_W'(HEIGHT - 1));

  always_comb begin
    state_d    = state_q;
    busy       = (state_q != ST_IDLE);
    frame_done = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE:   if (restart) state_d = ST_ACTIVE;
      ST_ACTIVE: if (pix_valid && !sof && last_pix) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (restart) state_d = ST_ACTIVE;
        else if (drain_cnt == DW'(SOBEL_LAT - 1)) state_d = ST_DONE;
      end
      ST_DONE:   state_d = restart ? ST_ACTIVE : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  sobel_line_buf #(.DEPTH(WIDTH), .AW(AW)) u_buf0 (
    .clock  (clock),
    .we     (accept),
    .addr   (cur_x[AW-1:0]),
    .wr_dat (pix_in),
    .rd_dat (l0_rd)
  );

  sobel_line_buf #(.DEPTH(WIDTH), .AW(AW)) u_buf1 (
    .clock  (clock),
    .we     (accept),
    .addr   (cur_x[AW-1:0]),
    .wr_dat (l0_rd),
    .rd_dat (l1_rd)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      drain_cnt <= '0;
      {z0, z1, z2, z3, z4, z5, z6, z7, z8} <= '0;
      win_valid <= 1'b0;
      win_cx    <= '0;
      win_cy    <= '0;
      dly_vld   <= '0;
      dly_x     <= '0;
      dly_y     <= '0;
    end else begin
      state_q   <= state_d;
      drain_cnt <= (state_q == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
      win_valid <= accept && (cur_x >= COORD_W'(2)) && (cur_y >= COORD_W'(2));

      if (accept) begin
        if (cur_x == COORD_W'(WIDTH - 1)) begin
          x_q <= '0;
          y_q <= cur_y + 1'b1;
        end else begin
          x_q <= cur_x + 1'b1;
          y_q <= cur_y;
        end
        {z0, z1, z2} <= {z1, z2, l1_rd};
        {z3, z4, z5} <= {z4, z5, l0_rd};
        {z6, z7, z8} <= {z7, z8, pix_in};
        win_cx <= cur_x - 1'b1;
        win_cy <= cur_y - 1'b1;
      end

      // Advances every clock: the datapath downstream never stalls.
      dly_vld[0] <= win_valid;
      dly_x[0]   <= win_cx;
      dly_y[0]   <= win_cy;
      for (int i = 1; i < SOBEL_LAT; i++) begin
        dly_vld[i] <= dly_vld[i-1];
        dly_x[i]   <= dly_x[i-1];
        dly_y[i]   <= dly_y[i-1];
      end
      if (restart) dly_vld <= '0;
    end
  end

  assign edge_valid = dly_vld[SOBEL_LAT-1];
  assign edge_x     = dly_x[SOBEL_LAT-1];
  assign edge_y     = dly_y[SOBEL_LAT-1];
  assign edge_out   = edge_valid ? sobel_edge : EDGE_OFF;

endmodule
